// File: rtl/if_fetch_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit_if
// Purpose  : Bus bundle between the fetch unit, its instruction ROM and the
//            IF/DF pipeline buffer.
// Revision : 1.0
// ============================================================================
interface if_fetch_unit_if #(
  parameter int PC_W   = 8,
  parameter int INST_W = 16
);
  logic              stall;
  logic              branch_taken;
  logic [PC_W-1:0]   branch_target;
  logic [3:0]        bubble_req;
  logic [INST_W-1:0] imem_data;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_en;
  logic [PC_W-1:0]   pc_out;
  logic [INST_W-1:0] inst_out;
  logic [3:0]        nop_out;
  logic              flush_out;

  // Fetch unit side
  modport slave (
    input  stall, branch_taken, branch_target, bubble_req, imem_data,
    output imem_addr, imem_en, pc_out, inst_out, nop_out, flush_out
  );

  // Pipeline / ROM side
  modport master (
    output stall, branch_taken, branch_target, bubble_req, imem_data,
    input  imem_addr, imem_en, pc_out, inst_out, nop_out, flush_out
  );
endinterface
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction fetch stage driving a 1-cycle-latency ROM, with stall,
//            branch redirect and bubble insertion toward the IF/DF buffer.
// Revision : 1.0
// ============================================================================
module if_fetch_unit #(
  parameter int PC_W   = 8,
  parameter int INST_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.slave  bus
);

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_BUBBLE = 2'd2;

  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   issue_pc_q, issue_pc_d;
  logic              valid_q, valid_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        state_q, state_d;

  logic              w_en;
  logic              w_bubble;
  logic              w_flush;
  logic              w_req;
  logic [INST_W-1:0] w_inst;

  assign w_req = (bus.bubble_req != 4'd0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    w_en       = 1'b0;
    w_bubble   = 1'b1;
    w_flush    = 1'b0;

    if (!rst) begin
      w_en     = 1'b0;
      w_bubble = 1'b1;
    end else if (bus.branch_taken) begin
      // Redirect: the ROM still reads this cycle, its data is discarded as a bubble.
      w_flush    = 1'b1;
      w_en       = 1'b1;
      fetch_pc_d = bus.branch_target;
      valid_d    = 1'b0;
      cnt_d      = 4'd0;
      state_d    = ST_RUN;
    end else if (bus.stall) begin
      w_en     = 1'b0;
      w_bubble = !valid_q || (state_q != ST_RUN);
    end else begin
      case (state_q)
        ST_FILL: begin
          w_en       = 1'b1;
          fetch_pc_d = fetch_pc_q + 1'b1;
          issue_pc_d = fetch_pc_q;
          valid_d    = 1'b1;
          state_d    = ST_RUN;
        end
        ST_RUN: begin
          if (w_req) begin
            // ROM holds its data so the current instruction is re-presented afterwards.
            w_en    = 1'b0;
            cnt_d   = bus.bubble_req - 4'd1;
            state_d = (bus.bubble_req > 4'd1) ? ST_BUBBLE : ST_RUN;
          end else begin
            w_en       = 1'b1;
            w_bubble   = !valid_q;
            fetch_pc_d = fetch_pc_q + 1'b1;
            issue_pc_d = fetch_pc_q;
            valid_d    = 1'b1;
          end
        end
        ST_BUBBLE: begin
          w_en  = 1'b0;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          w_en    = 1'b0;
          state_d = ST_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= '0;
      issue_pc_q <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= 4'd0;
      state_q    <= ST_FILL;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
    end
  end

  assign w_inst        = w_bubble ? '0 : bus.imem_data;

  assign bus.imem_addr = fetch_pc_q;
  assign bus.imem_en   = w_en;
  assign bus.pc_out    = issue_pc_q;
  assign bus.inst_out  = w_inst;
  assign bus.nop_out   = w_bubble ? 4'hF : 4'h0;
  assign bus.flush_out = w_flush;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Randomized scoreboard bench for if_fetch_unit with a ROM model
//            holding ROM[k] = 16'hA000 + k.
// Revision : 1.0
// ============================================================================
module tb_if_fetch_unit;

  logic clk;
  logic rst;

  if_fetch_unit_if #(.PC_W(8), .INST_W(16)) bus ();

  if_fetch_unit #(.PC_W(8), .INST_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_data <= 16'hA000 + {8'h00, bus.imem_addr};
  end

  typedef struct {
    logic        pcv;
    logic [7:0]  pc;
    logic [15:0] inst;
    logic [3:0]  nop;
    logic        flush;
    logic        en;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference: m_pc is the next instruction to be shown; m_fill/m_lead/m_hold
  // count bubble cycles still owed before it appears.
  logic [7:0] m_pc   = 8'h00;
  int         m_hold = 0;
  logic       m_lead = 1'b0;
  logic       m_fill = 1'b1;

  task automatic cyc(input logic r, input logic s, input logic b,
                     input logic [7:0] t, input logic [3:0] n);
    exp_t e;
    logic show;
    @(posedge clk);
    #1;
    rst               = r;
    bus.stall         = s;
    bus.branch_taken  = b;
    bus.branch_target = t;
    bus.bubble_req    = n;
    show    = 1'b0;
    e.pcv   = 1'b0;
    e.pc    = 8'h00;
    e.inst  = 16'h0000;
    e.nop   = 4'hF;
    e.flush = 1'b0;
    e.en    = 1'b0;
    if (!r) begin
      m_pc = 8'h00; m_hold = 0; m_lead = 1'b0; m_fill = 1'b1;
    end else if (b) begin
      e.flush = 1'b1; e.en = 1'b1;
      m_pc = t; m_lead = 1'b1; m_fill = 1'b0; m_hold = 0;
    end else if (s) begin
      show = (m_hold == 0) && !m_fill && !m_lead;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
    end else if (m_fill) begin
      e.en = 1'b1; m_fill = 1'b0;
    end else if (n != 4'd0) begin
      m_hold = int'(n) - 1;
    end else if (m_lead) begin
      e.en = 1'b1; m_lead = 1'b0;
    end else begin
      e.en = 1'b1; show = 1'b1;
    end
    if (show) begin
      e.pcv  = 1'b1;
      e.pc   = m_pc;
      e.inst = 16'hA000 + {8'h00, m_pc};
      e.nop  = 4'h0;
      if (!s) m_pc = m_pc + 8'd1;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
  endtask

  initial begin : monitor
    exp_t e;
    logic bad;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        bad = (bus.flush_out !== e.flush) || (bus.imem_en !== e.en) ||
              (bus.nop_out !== e.nop) || (bus.inst_out !== e.inst) ||
              (e.pcv && (bus.pc_out !== e.pc));
        if (bad) begin
          n_bad++;
          $display("FAIL vec%0d: got pc=%h inst=%h nop=%h flush=%b en=%b; want pc=%h(chk=%b) inst=%h nop=%h flush=%b en=%b",
                   n_vec, bus.pc_out, bus.inst_out, bus.nop_out, bus.flush_out, bus.imem_en,
                   e.pc, e.pcv, e.inst, e.nop, e.flush, e.en);
        end
      end
    end
  end

  initial begin : stim
    rst               = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 8'h00;
    bus.bubble_req    = 4'd0;

    // Reset and fill: bubble, then 00, 01, ... 05
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
    idle(7);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
    idle(2);
    // Branch to 40, branch overriding stall, then a 3-cycle bubble request
    cyc(1'b1, 1'b0, 1'b1, 8'h40, 4'd0);
    idle(4);
    cyc(1'b1, 1'b1, 1'b1, 8'h10, 4'd0);
    idle(3);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 4'd3);
    idle(3);
    // Branch wins over a simultaneous bubble request; wrap through FF
    cyc(1'b1, 1'b0, 1'b1, 8'hFE, 4'd3);
    idle(5);
    // Reset in the middle of a bubble run, plus requests ignored in FILL/BUBBLE
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 4'd6);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 4'd2);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 4'd5);
    idle(3);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 4'd1);
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      logic       r, s, b;
      logic [7:0] t;
      logic [3:0] n;
      r = ($urandom_range(0, 99) != 0);
      b = ($urandom_range(0, 11) == 0);
      s = ($urandom_range(0, 5) == 0);
      n = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      t = ($urandom_range(0, 7) == 0) ? 8'hFE : 8'($urandom);
      cyc(r, s, b, t, n);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
